// File: rtl/imu_sched_pkg.sv
// imu_sched_pkg: state encoding and burst constants shared by the IMU read scheduler.
package imu_sched_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACC_START = 3'd1,
      ACC_XFER  = 3'd2,
      GYR_START = 3'd3,
      GYR_XFER  = 3'd4,
      PUBLISH   = 3'd5
   } state_t;
   localparam logic [7:0] SPI_READ_BIT = 8'h80;
   localparam logic [2:0] BURST_BYTES  = 3'd7;
   localparam logic [2:0] LAST_IDX     = 3'd6;
   localparam int         AXIS_W       = 16;
endpackage

// File: rtl/imu_burst_assembler.sv
// imu_burst_assembler: collects burst bytes 1..6 (high byte first) into three axis words.
module imu_burst_assembler
   import imu_sched_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              strobe_i,
   input  logic [2:0]        idx_i,
   input  logic [7:0]        rx_i,
   output logic [AXIS_W-1:0] x_o,
   output logic [AXIS_W-1:0] y_o,
   output logic [AXIS_W-1:0] z_o
);
   logic [3*AXIS_W-1:0] shadow_q, shadow_d;
   int sh;
   // Byte 0 is the address slot and carries no data.
   always_comb begin
      sh = 8 * (6 - int'(idx_i));
      shadow_d = shadow_q;
      if (clear_i)
         shadow_d = '0;
      else if (strobe_i && idx_i != 3'd0 && idx_i <= LAST_IDX)
         shadow_d = (shadow_q & ~({40'b0, 8'hFF} << sh)) | ({40'b0, rx_i} << sh);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) shadow_q <= '0;
      else shadow_q <= shadow_d;
   assign {x_o, y_o, z_o} = shadow_q;
endmodule

// File: rtl/imu_read_scheduler.sv
// imu_read_scheduler: per sample_tick, reads an accel then a gyro burst over SPI and publishes six words.
module imu_read_scheduler
  import imu_sched_pkg::*;
#(
  parameter logic [7:0] ACCEL_DATA_ADDR = 8'h3B,
  parameter logic [7:0] GYRO_DATA_ADDR  = 8'h43,
  parameter int         TIMEOUT_CYCLES  = 1024
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  output logic        sensor_select,
  output logic        spi_start,
  output logic [2:0]  spi_count_bytes,
  output logic [7:0]  spi_tx_data,
  input  logic        spi_byte_done,
  input  logic [7:0]  spi_rx_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [7:0] tx_q, tx_d;
  logic ovr_q;
  logic [3*AXIS_W-1:0] acc_hold_q, pub_acc_q, pub_gyr_q;
  logic [AXIS_W-1:0] sx, sy, sz;
  logic xfer, start, last, abort;
  assign xfer            = state_q == ACC_XFER || state_q == GYR_XFER;
  assign start           = state_q == ACC_START || state_q == GYR_START;
  assign last            = xfer && spi_byte_done && k_q == LAST_IDX;
  assign spi_start       = start;
  assign sensor_select   = state_q == GYR_START || state_q == GYR_XFER;
  assign busy            = state_q != IDLE && state_q != PUBLISH;
  assign sample_valid    = state_q == PUBLISH;
  assign spi_count_bytes = BURST_BYTES;
  assign spi_tx_data     = tx_q;
  assign overrun         = ovr_q;
  assign {accel_x, accel_y, accel_z} = sample_valid ? acc_hold_q : pub_acc_q;
  assign {gyro_x, gyro_y, gyro_z}    = sample_valid ? {sx, sy, sz} : pub_gyr_q;
`ifdef IMU_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic to_q;
  assign abort = xfer && !spi_byte_done && wd_q == WD_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= (xfer && !spi_byte_done && !abort) ? wd_q + 1'b1 : '0;
      to_q <= to_q | abort;
    end
  assign timeout_err = to_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = sample_tick ? ACC_START : IDLE;
      ACC_START: state_d = ACC_XFER;
      ACC_XFER:  state_d = last ? GYR_START : ACC_XFER;
      GYR_START: state_d = GYR_XFER;
      GYR_XFER:  state_d = last ? PUBLISH : GYR_XFER;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    k_d  = start ? 3'd0 : (xfer && spi_byte_done) ? k_q + 3'd1 : k_q;
    tx_d = state_d == ACC_START ? (SPI_READ_BIT | ACCEL_DATA_ADDR) :
           state_d == GYR_START ? (SPI_READ_BIT | GYRO_DATA_ADDR) :
           (xfer && spi_byte_done) ? 8'h00 : tx_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      tx_q       <= '0;
      ovr_q      <= 1'b0;
      acc_hold_q <= '0;
      pub_acc_q  <= '0;
      pub_gyr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_q | (sample_tick && state_q != IDLE);
      if (state_q == GYR_START) acc_hold_q <= {sx, sy, sz};
      if (sample_valid) begin
        pub_acc_q <= acc_hold_q;
        pub_gyr_q <= {sx, sy, sz};
      end
    end
  imu_burst_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start),
    .strobe_i (xfer && spi_byte_done),
    .idx_i    (k_q),
    .rx_i     (spi_rx_data),
    .x_o      (sx),
    .y_o      (sy),
    .z_o      (sz)
  );
endmodule

// File: tb/tb_imu_read_scheduler.sv
// tb_imu_read_scheduler: directed checks of the IMU read scheduler with a simple SPI engine model.
module tb_imu_read_scheduler;
  logic clk = 1'b0, reset = 1'b1, sample_tick = 1'b0, spi_byte_done = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic sensor_select, spi_start, sample_valid, busy, overrun, timeout_err;
  logic [2:0] spi_count_bytes;
  logic [7:0] spi_tx_data;
  logic [15:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
  int checks = 0, errors = 0, valid_cnt = 0, start_cnt = 0;
  int v0, s0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sample_valid) valid_cnt++;
    if (spi_start) start_cnt++;
  end
  imu_read_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .sensor_select(sensor_select),
    .spi_start(spi_start), .spi_count_bytes(spi_count_bytes), .spi_tx_data(spi_tx_data),
    .spi_byte_done(spi_byte_done), .spi_rx_data(spi_rx_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {sensor_select, spi_start, busy, sample_valid, overrun, timeout_err, spi_tx_data}, 0);
    chk(tag, {accel_x, accel_y, accel_z}, 0);
    chk(tag, {gyro_x, gyro_y, gyro_z}, 0);
  endtask
  task automatic burst(input logic sel, input logic [7:0] addr, input logic [55:0] b,
                       input int nbytes, input int tick_k);
    int n = 0;
    while (!spi_start && n < 20) begin
      step();
      n++;
    end
    chk("start_seen", spi_start, 1);
    chk("sel_start", sensor_select, sel);
    chk("count_bytes", spi_count_bytes, 7);
    chk("tx_addr", spi_tx_data, 8'h80 | addr);
    chk("busy_start", busy, 1);
    step();
    chk("start_one_cycle", spi_start, 0);
    for (int k = 0; k < nbytes; k++) begin
      step();
      spi_byte_done = 1'b1;
      spi_rx_data = b[55-8*k -: 8];
      sample_tick = (k == tick_k);
      chk("sel_xfer", sensor_select, sel);
      step();
      spi_byte_done = 1'b0;
      spi_rx_data = 8'h00;
      sample_tick = 1'b0;
      if (k < 6) chk("tx_zero", spi_tx_data, 0);
    end
  endtask
  task automatic check_pub(input logic [95:0] e);
    chk("pub_valid", sample_valid, 1);
    chk("pub_busy", busy, 0);
    chk("pub_sel", sensor_select, 0);
    chk("pub_accel", {accel_x, accel_y, accel_z}, e[95:48]);
    chk("pub_gyro", {gyro_x, gyro_y, gyro_z}, e[47:0]);
  endtask
  task automatic round(input logic [55:0] a, input logic [55:0] g, input logic [95:0] e);
    pulse_tick();
    burst(1'b0, 8'h3B, a, 7, -1);
    burst(1'b1, 8'h43, g, 7, -1);
    check_pub(e);
  endtask
  initial begin
    #3;
    chk_zero("reset_held");
    step();
    step();
    reset = 1'b0;
    step();
    chk_zero("after_reset");
    v0 = valid_cnt; s0 = start_cnt;
    round(56'hFF010203040506, 56'hFF102030405060, 96'h0102_0304_0506_1020_3040_5060);
    step();
    chk("valid_one_cycle", sample_valid, 0);
    chk("hold_accel", {accel_x, accel_y, accel_z}, 48'h0102_0304_0506);
    chk("hold_gyro", {gyro_x, gyro_y, gyro_z}, 48'h1020_3040_5060);
    chk("valid_count_r1", valid_cnt - v0, 1);
    chk("start_count_r1", start_cnt - s0, 2);
    spi_byte_done = 1'b1; spi_rx_data = 8'hAA;
    step();
    spi_byte_done = 1'b0; spi_rx_data = 8'h00;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_tx", spi_tx_data, 0);
    v0 = valid_cnt; s0 = start_cnt;
    pulse_tick();
    burst(1'b0, 8'h3B, 56'hFFA1A2A3A4A5A6, 7, 2);
    chk("no_midround_change", {accel_x, accel_y, accel_z}, 48'h0102_0304_0506);
    chk("overrun_set", overrun, 1);
    burst(1'b1, 8'h43, 56'hFFB1B2B3B4B5B6, 7, -1);
    check_pub(96'hA1A2_A3A4_A5A6_B1B2_B3B4_B5B6);
    repeat (6) step();
    chk("dropped_tick_idle", busy, 0);
    chk("valid_count_ovr", valid_cnt - v0, 1);
    chk("start_count_ovr", start_cnt - s0, 2);
    round(56'hFF111122223333, 56'hFF444455556666, 96'h1111_2222_3333_4444_5555_6666);
    chk("overrun_sticky", overrun, 1);
    step();
    pulse_tick();
    burst(1'b0, 8'h3B, 56'hFF0A0B0C0D0E0F, 7, -1);
    burst(1'b1, 8'h43, 56'hFF1A1B1C1D1E1F, 3, -1);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    step();
    reset = 1'b0;
    step();
    round(56'hFF123456789ABC, 56'hFFFEDCBA987654, 96'h1234_5678_9ABC_FEDC_BA98_7654);
    chk("overrun_cleared", overrun, 0);
    v0 = valid_cnt;
    step();
    round(56'hFF800080017FFF, 56'hFF0001FFFF8000, 96'h8000_8001_7FFF_0001_FFFF_8000);
    step();
    round(56'hFF00000000CAFE, 56'hFFBEEF00000000, 96'h0000_0000_CAFE_BEEF_0000_0000);
    chk("b2b_valid_count", valid_cnt - v0, 2);
    chk("b2b_overrun", overrun, 0);
    step();
`ifdef IMU_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      v0 = valid_cnt;
      pulse_tick();
      burst(1'b0, 8'h3B, 56'hFF999999999999, 7, -1);
      burst(1'b1, 8'h43, 56'hFF888888888888, 4, -1);
      while (busy && n < 40) begin
        step();
        n++;
      end
      chk("timeout_abort", busy, 0);
      chk("timeout_err", timeout_err, 1);
      chk("timeout_sel", sensor_select, 0);
      chk("timeout_no_valid", valid_cnt - v0, 0);
      chk("timeout_keep_accel", {accel_x, accel_y, accel_z}, 48'h0000_0000_CAFE);
      chk("timeout_keep_gyro", {gyro_x, gyro_y, gyro_z}, 48'hBEEF_0000_0000);
      step();
      round(56'hFF010101010101, 56'hFF020202020202, 96'h0101_0101_0101_0202_0202_0202);
      chk("timeout_sticky", timeout_err, 1);
    end
`else
    chk("timeout_tied_low", timeout_err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
